reg_file_gen: RTL and testbench
===============================

REG_FILE_GEN -- requirements
Module: reg_file_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter LINK_REG, default DEPTH-1, index of the link (return-address) register.
REQ-004 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_R0, default 0, making register 0 read-only zero when 1.
REQ-006 SHALL have one clock and one reset: clk  input  1  rising-edge clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 clr_req  input  1  request a full sequential clear.
REQ-009 busy  output  1  clear in progress; all writes ignored.
REQ-010 rr1, rr2  input  ADDR_W  read addresses.
REQ-011 mem  input  1  load/store mode; rd1 sources rr2 instead of rr1.
REQ-012 rd1, rd2  output  DATA_W  read data ports.
REQ-013 store_data  output  DATA_W  contents of register rr1 (store operand).
REQ-014 ra  output  DATA_W  contents of LINK_REG.
REQ-015 we, wr, wdata  input  1/ADDR_W/DATA_W  general write port.
REQ-016 link_we, link_data  input  1/DATA_W  link write port, always targets LINK_REG.

Function
REQ-017 SHALL implement FSM states CLEAR and IDLE, plus a clear pointer clr_ptr of ADDR_W bits.
REQ-018 In CLEAR, each rising edge SHALL write 0 to register[clr_ptr] and increment clr_ptr.
REQ-019 CLEAR SHALL move to IDLE on the edge that clears register DEPTH-1; a full clear takes exactly DEPTH cycles.
REQ-020 busy SHALL be 1 in CLEAR and 0 in IDLE, decoded from state with no extra cycle.
REQ-021 In IDLE, clr_req=1 at an edge SHALL enter CLEAR with clr_ptr=0; clr_req during CLEAR SHALL be ignored, with no restart.
REQ-022 In IDLE with no clr_req, we=1 SHALL write wdata to register[wr], and link_we=1 SHALL write link_data to LINK_REG, on the rising edge.
REQ-023 If we=1, wr=LINK_REG and link_we=1 in the same cycle, link_data SHALL win.
REQ-024 clr_req=1 together with we/link_we in IDLE SHALL perform the writes and start CLEAR on the same edge.
REQ-025 With ZERO_R0=1, writes to register 0 SHALL be dropped and reads of address 0 SHALL return 0.
REQ-026 Reads SHALL be combinational: rd1 = reg[mem ? rr2 : rr1], rd2 = reg[rr2], store_data = reg[rr1], ra = reg[LINK_REG].
REQ-027 With BYPASS=1, a read whose address matches an enabled, non-dropped write this cycle SHALL return that write's data, with link priority per REQ-023; with BYPASS=0, reads return pre-edge contents.
REQ-028 While busy=1, rd1, rd2, store_data and ra SHALL all read 0 regardless of array contents.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W bits; clr_ptr SHALL wrap to 0 on the last clear.

Reset
REQ-030 rst=1 SHALL immediately force state=CLEAR and clr_ptr=0, so busy=1 and all read outputs are 0; the array itself is not touched asynchronously.
REQ-031 After rst deasserts, clearing SHALL proceed per REQ-018/019; busy falls DEPTH edges later.
REQ-032 rst asserted mid-clear SHALL restart the clear from clr_ptr=0.

Verification
REQ-033 Reset: pulse rst, defaults -> busy=1 for exactly 32 edges, then 0; all 32 registers read 0.
REQ-034 Write/read: we=1, wr=5, wdata=0xDEADBEEF, then rr1=5, mem=0 -> rd1=store_data=0xDEADBEEF next cycle; with mem=1, rr2=5 -> rd1=0xDEADBEEF.
REQ-035 Bypass and conflict: same cycle we=1, wr=31, wdata=0x11, link_we=1, link_data=0x22, rr2=31 -> rd2=0x22 combinationally; ra=0x22 after the edge; repeat with BYPASS=0 -> rd2 shows the old value before the edge.
REQ-036 Clear mid-operation: fill r1..r31 with nonzero values, assert clr_req, then assert clr_req again 10 cycles later -> busy high for exactly 32 edges and no restart; we during busy is ignored; all registers 0 afterwards.
REQ-037 ZERO_R0=1, DATA_W=16, ADDR_W=3: we=1, wr=0, wdata=0xFFFF -> rd1 for rr1=0 stays 0; busy lasts 8 edges after reset.
REQ-038 Reset mid-clear: assert rst at clr_ptr=12 -> outputs 0 immediately; after release, busy lasts a further full DEPTH edges.

Source files
------------

// File: rtl/reg_file_gen.sv
// reg_file_gen: register file with a link register and a sequential clear FSM.
// Read ports optionally forward same-cycle writes. All reads return 0 while a clear is running.
module reg_file_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 2**ADDR_W - 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  input  logic              mem,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] ra,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic w_ok, l_ok;
  assign busy = state == CLEAR;
  assign w_ok = !busy && we && !(ZERO_R0 != 0 && wr == '0);
  assign l_ok = !busy && link_we && !(ZERO_R0 != 0 && LINK_A == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) state <= IDLE;
    end else if (clr_req) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end
  end
  // The link write is issued last so it overrides a general write to LINK_REG.
  always_ff @(posedge clk) begin
    if (busy) regs[clr_ptr] <= '0;
    else begin
      if (w_ok) regs[wr] <= wdata;
      if (l_ok) regs[LINK_A] <= link_data;
    end
  end
  function automatic logic [DATA_W-1:0] rd_at(input logic [ADDR_W-1:0] a);
    return (busy || (ZERO_R0 != 0 && a == '0)) ? '0 :
           (BYPASS != 0 && l_ok && a == LINK_A) ? link_data :
           (BYPASS != 0 && w_ok && a == wr) ? wdata : regs[a];
  endfunction
  assign rd1        = rd_at(mem ? rr2 : rr1);
  assign rd2        = rd_at(rr2);
  assign store_data = rd_at(rr1);
  assign ra         = rd_at(LINK_A);
endmodule

// File: tb/tb_reg_file_gen.sv
// tb_reg_file_gen: directed checks of reg_file_gen in default, no-bypass and small zero-r0 configurations.
module tb_reg_file_gen;
  logic clk = 0, rst = 1, clr_req = 0, mem = 0, we = 0, link_we = 0;
  logic [4:0] rr1 = 0, rr2 = 0, wr = 0;
  logic [31:0] wdata = 0, link_data = 0;
  logic busy0, busy1, busy2;
  logic [31:0] rd1_0, rd2_0, sd0, ra0, rd1_1, rd2_1, sd1, ra1;
  logic clr_s = 0, mem_s = 0, we_s = 0, lwe_s = 0;
  logic [2:0] rr1_s = 0, rr2_s = 0, wr_s = 0;
  logic [15:0] wdata_s = 0, ldata_s = 0, rd1_2, rd2_2, sd2, ra2;
  int checks = 0, failures = 0;
  int f0, f1, f2;
  always #5 clk = ~clk;
  reg_file_gen u0 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0), .rr1(rr1), .rr2(rr2), .mem(mem),
    .rd1(rd1_0), .rd2(rd2_0), .store_data(sd0), .ra(ra0), .we(we), .wr(wr), .wdata(wdata),
    .link_we(link_we), .link_data(link_data));
  reg_file_gen #(.BYPASS(0)) u1 (.clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1), .rr1(rr1), .rr2(rr2),
    .mem(mem), .rd1(rd1_1), .rd2(rd2_1), .store_data(sd1), .ra(ra1), .we(we), .wr(wr), .wdata(wdata),
    .link_we(link_we), .link_data(link_data));
  reg_file_gen #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) u2 (.clk(clk), .rst(rst), .clr_req(clr_s), .busy(busy2),
    .rr1(rr1_s), .rr2(rr2_s), .mem(mem_s), .rd1(rd1_2), .rd2(rd2_2), .store_data(sd2), .ra(ra2), .we(we_s),
    .wr(wr_s), .wdata(wdata_s), .link_we(lwe_s), .link_data(ldata_s));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic count_clear(input string tag, output int fall);
    fall = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin clr_req = 1; we = 1; wr = 3; wdata = 32'hAA; end
      if (i == 11) begin clr_req = 0; we = 0; end
      tick;
      if (!busy0 && fall == 0) fall = i;
    end
    check(tag, fall, 32);
  endtask
  initial begin
    tick; tick;
    check("rst_busy", busy0, 1);
    check("rst_ra", ra0, 0);
    rst = 0;
    f0 = 0; f1 = 0; f2 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (!busy0 && f0 == 0) f0 = i;
      if (!busy1 && f1 == 0) f1 = i;
      if (!busy2 && f2 == 0) f2 = i;
    end
    check("rst_len0", f0, 32);
    check("rst_len1", f1, 32);
    check("rst_len_small", f2, 8);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); #1;
      check($sformatf("zero_r%0d", i), rd1_0, 0);
    end
    we = 1; wr = 5; wdata = 32'hDEADBEEF;
    tick;
    we = 0; rr1 = 5; mem = 0; #1;
    check("wr_rd1", rd1_0, 32'hDEADBEEF);
    check("wr_store", sd0, 32'hDEADBEEF);
    mem = 1; rr2 = 5; rr1 = 0; #1;
    check("mem_rd1", rd1_0, 32'hDEADBEEF);
    check("mem_store", sd0, 0);
    mem = 0;
    we = 1; wr = 31; wdata = 32'h11; link_we = 1; link_data = 32'h22; rr2 = 31; #1;
    check("byp_rd2", rd2_0, 32'h22);
    check("nobyp_rd2", rd2_1, 0);
    tick;
    we = 0; link_we = 0; #1;
    check("link_ra", ra0, 32'h22);
    check("link_ra_nobyp", ra1, 32'h22);
    we = 1; wr = 7; wdata = 32'h77; rr1 = 7; #1;
    check("byp_wr", rd1_0, 32'h77);
    check("nobyp_wr", rd1_1, 0);
    tick;
    we = 0; #1;
    check("wr7_nobyp", rd1_1, 32'h77);
    for (int i = 1; i < 32; i++) begin
      we = 1; wr = 5'(i); wdata = 32'h01010101 * i;
      tick;
    end
    we = 0; rr1 = 17; #1;
    check("fill_r17", sd0, 32'h11111111);
    check("fill_ra", ra0, 32'h1F1F1F1F);
    clr_req = 1;
    tick;
    clr_req = 0; #1;
    check("clr_busy", busy0, 1);
    check("clr_rd_zero", sd0, 0);
    count_clear("clr_len", f0);
    for (int i = 0; i < 32; i++) begin
      rr2 = 5'(i); #1;
      check($sformatf("clr_r%0d", i), rd2_0, 0);
    end
    we_s = 1; wr_s = 0; wdata_s = 16'hFFFF; rr1_s = 0; #1;
    check("z0_byp", 32'(rd1_2), 0);
    tick;
    wr_s = 2; wdata_s = 16'h1234; #1;
    check("z0_after", 32'(rd1_2), 0);
    tick;
    we_s = 0; rr1_s = 2; #1;
    check("small_r2", 32'(rd1_2), 32'h1234);
    rr1 = 5; we = 1; wr = 5; wdata = 32'h5555;
    tick;
    we = 0; #1;
    check("pre_rst", rd1_0, 32'h5555);
    rst = 1; #1;
    check("async_busy", busy0, 1);
    check("async_rd", rd1_0, 0);
    tick;
    rst = 0;
    for (int i = 0; i < 45; i++) tick;
    clr_req = 1;
    tick;
    clr_req = 0;
    for (int i = 0; i < 12; i++) tick;
    rst = 1; #1;
    check("mid_busy", busy0, 1);
    tick;
    rst = 0;
    f0 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (!busy0 && f0 == 0) f0 = i;
    end
    check("mid_len", f0, 32);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
